// File: rtl/jtdd_adpcm_arb.sv
// Two-channel ADPCM ROM arbiter: one-byte cache per channel, misses fetched
// round-robin through a single SDRAM slot with a stale-ok guard window.

module jtdd_adpcm_arb_lane #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          fill,
  input  logic [AW-1:0] fill_tag,
  input  logic [7:0]    fill_data,
  output logic          ok,
  output logic          miss,
  output logic [7:0]    data
);
  logic [AW-1:0] tag;
  logic          valid;
  logic          hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else if (fill) begin
      tag   <= fill_tag;
      data  <= fill_data;
      valid <= 1'b1;
    end
  end

  // Hits are combinational so a cached byte comes back in the same cycle
  assign hit  = valid & (tag == addr);
  assign ok   = cs & hit;
  assign miss = cs & ~hit;
endmodule

module jtdd_adpcm_arb #(
  parameter int AW  = 16,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ch0_addr,
  input  logic          ch0_cs,
  output logic [7:0]    ch0_data,
  output logic          ch0_ok,
  input  logic [AW-1:0] ch1_addr,
  input  logic          ch1_cs,
  output logic [7:0]    ch1_data,
  output logic          ch1_ok,
  output logic [AW:0]   rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok
);
  localparam int NUM_LANES = 2;
  localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_WAIT} st_t;

  st_t                             st;
  logic                            sel, last, pick;
  logic [AW-1:0]                   fadr;
  logic [CW-1:0]                   cnt;
  logic                            fill;
  logic [NUM_LANES-1:0][AW-1:0]    lane_addr;
  logic [NUM_LANES-1:0][7:0]       lane_data;
  logic [NUM_LANES-1:0]            lane_cs, lane_ok, lane_miss, lane_fill;

  assign lane_addr = {ch1_addr, ch0_addr};
  assign lane_cs   = {ch1_cs, ch0_cs};
  assign fill      = (st == ST_WAIT) & rom_ok;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      assign lane_fill[i] = fill & (sel == 1'(i));
      jtdd_adpcm_arb_lane #(.AW(AW)) u_lane (
        .clk       (clk),
        .rst       (rst),
        .addr      (lane_addr[i]),
        .cs        (lane_cs[i]),
        .fill      (lane_fill[i]),
        .fill_tag  (fadr),
        .fill_data (rom_data),
        .ok        (lane_ok[i]),
        .miss      (lane_miss[i]),
        .data      (lane_data[i])
      );
    end
  endgenerate

  assign ch0_ok   = lane_ok[0];
  assign ch1_ok   = lane_ok[1];
  assign ch0_data = lane_data[0];
  assign ch1_data = lane_data[1];

  // On contention take the channel not served last; otherwise the lone miss
  assign pick = (&lane_miss) ? ~last : lane_miss[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      last     <= 1'b1;
      sel      <= 1'b0;
      fadr     <= '0;
      cnt      <= '0;
    end else begin
      case (st)
        ST_IDLE: if (|lane_miss) begin
          sel      <= pick;
          last     <= pick;
          fadr     <= lane_addr[pick];
          rom_addr <= {pick, lane_addr[pick]};
          rom_cs   <= 1'b1;
          cnt      <= CW'(GAP);
          st       <= (GAP == 0) ? ST_WAIT : ST_GAP;
        end
        ST_GAP: begin
          cnt <= cnt - CW'(1);
          if (cnt <= CW'(1)) st <= ST_WAIT;
        end
        ST_WAIT: if (rom_ok) begin
          rom_cs <= 1'b0;
          st     <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtdd_adpcm_arb.sv
// Scoreboarded bench for jtdd_adpcm_arb: expected SDRAM addresses are queued
// as requests are driven and matched against each rom_cs rising edge.

module tb_jtdd_adpcm_arb;
  localparam int AW = 16;
  localparam int SD_LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ch0_addr = '0, ch1_addr = '0;
  logic          ch0_cs = 1'b0, ch1_cs = 1'b0;
  logic [7:0]    ch0_data, ch1_data;
  logic          ch0_ok, ch1_ok;
  logic [AW:0]   rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;

  logic          ok_r = 1'b0, stale_mode = 1'b0, late_ok = 1'b0;
  int            sd_cnt = 0;
  logic [31:0]   cyc = '0;

  int            n_chk = 0, n_pass = 0, fetch_cnt = 0;
  logic [AW:0]   exp_q[$];
  logic          cs_prev = 1'b0;
  logic [AW:0]   held = '0;

  jtdd_adpcm_arb #(.AW(AW), .GAP(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .ch0_addr (ch0_addr),
    .ch0_cs   (ch0_cs),
    .ch0_data (ch0_data),
    .ch0_ok   (ch0_ok),
    .ch1_addr (ch1_addr),
    .ch1_cs   (ch1_cs),
    .ch1_data (ch1_data),
    .ch1_ok   (ch1_ok),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [AW:0] a);
    if (a == 17'h01234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ {a[16], 7'h00} ^ 8'h3C;
  endfunction

  // SDRAM model: one-cycle ok pulse SD_LAT cycles after rom_cs rises
  assign rom_ok   = ok_r | stale_mode | late_ok;
  assign rom_data = mem(rom_addr) ^ (stale_mode ? cyc[7:0] : 8'h00);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rom_cs || rom_ok) begin
      sd_cnt <= 0;
      ok_r   <= 1'b0;
    end else begin
      sd_cnt <= sd_cnt + 1;
      ok_r   <= (sd_cnt == SD_LAT - 1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  // Fetch monitor: each new rom_cs pulse must match the queue head and hold its address
  always @(negedge clk) begin
    if (rom_cs && !cs_prev) begin
      fetch_cnt <= fetch_cnt + 1;
      chk("fetch_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("rom_addr", 32'(rom_addr), 32'(exp_q.pop_front()));
      held <= rom_addr;
    end else if (rom_cs && cs_prev) begin
      chk("addr_stable", 32'(rom_addr), 32'(held));
    end
    cs_prev <= rom_cs;
  end

  task automatic wait_ok(input int ch, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ch == 0 ? ch0_ok : ch1_ok) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, 32'(got), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch0_cs = 1'b0;
    ch1_cs = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int fc;
    logic [31:0] w;
    logic got;
    logic [AW-1:0] wrap_a[3];

    // Reset state, with a request present so ok exercises the valid bit
    repeat (2) @(negedge clk);
    ch0_cs = 1'b1;
    ch1_cs = 1'b1;
    #1;
    chk("rst_rom_cs", 32'(rom_cs), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_ch0_ok", 32'(ch0_ok), 0);
    chk("rst_ch1_ok", 32'(ch1_ok), 0);
    chk("rst_ch0_data", 32'(ch0_data), 0);
    chk("rst_ch1_data", 32'(ch1_data), 0);
    ch0_cs = 1'b0;
    ch1_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single miss, then hold: hit served with no extra fetch
    exp_q.push_back(17'h01234);
    ch0_addr = 16'h1234;
    ch0_cs   = 1'b1;
    wait_ok(0, "t1_ok");
    chk("t1_data", 32'(ch0_data), 32'h A5);
    fc = fetch_cnt;
    repeat (8) @(negedge clk);
    chk("t1_hold_ok", 32'(ch0_ok), 1);
    chk("t1_no_refetch", 32'(fetch_cnt), 32'(fc));

    // Simultaneous miss after reset: ch0 first
    do_reset();
    exp_q.push_back(17'h00010);
    exp_q.push_back(17'h10020);
    ch0_addr = 16'h0010; ch1_addr = 16'h0020;
    ch0_cs = 1'b1; ch1_cs = 1'b1;
    wait_ok(1, "t2_ch1_ok");
    chk("t2_ch0_ok", 32'(ch0_ok), 1);
    chk("t2_ch0_data", 32'(ch0_data), 32'(mem(17'h00010)));
    chk("t2_ch1_data", 32'(ch1_data), 32'(mem(17'h10020)));
    // A lone ch0 fetch leaves last=0, so the next contention goes to ch1
    exp_q.push_back(17'h00011);
    ch0_addr = 16'h0011;
    wait_ok(0, "t2_solo_ok");
    exp_q.push_back(17'h10021);
    exp_q.push_back(17'h00012);
    ch0_addr = 16'h0012; ch1_addr = 16'h0021;
    wait_ok(0, "t2_alt_ch0_ok");
    chk("t2_alt_ch1_ok", 32'(ch1_ok), 1);
    chk("t2_alt_ch1_data", 32'(ch1_data), 32'(mem(17'h10021)));
    ch1_cs = 1'b0;

    // rom_ok stuck high: no fill in GAP, fill on the first WAIT cycle
    stale_mode = 1'b1;
    exp_q.push_back(17'h00200);
    ch0_addr = 16'h0200;
    @(negedge clk);
    chk("t3_gap_cs", 32'(rom_cs), 1);
    chk("t3_gap_no_fill", 32'(ch0_ok), 0);
    @(negedge clk);
    chk("t3_wait_no_fill", 32'(ch0_ok), 0);
    w = cyc;
    @(negedge clk);
    stale_mode = 1'b0;
    chk("t3_fill_ok", 32'(ch0_ok), 1);
    chk("t3_fill_data", 32'(ch0_data), 32'(mem(17'h00200) ^ {24'h0, w[7:0]}));

    // Address changes during WAIT: old address is filled, then a refetch
    exp_q.push_back(17'h00100);
    exp_q.push_back(17'h00101);
    ch0_addr = 16'h0100;
    repeat (2) @(negedge clk);
    ch0_addr = 16'h0101;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!rom_cs) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("t4_fill_seen", 32'(got), 1);
    chk("t4_stale_no_ok", 32'(ch0_ok), 0);
    ch0_addr = 16'h0100;
    #1;
    chk("t4_tag_old", 32'(ch0_ok), 1);
    ch0_addr = 16'h0101;
    wait_ok(0, "t4_refetch_ok");
    chk("t4_refetch_data", 32'(ch0_data), 32'(mem(17'h00101)));
    ch0_cs = 1'b0;

    // Reset in WAIT with a late ok: no fill, caches cleared, FSM idle
    exp_q.push_back(17'h10300);
    ch1_addr = 16'h0300;
    ch1_cs   = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_in_wait_cs", 32'(rom_cs), 1);
    rst = 1'b1;
    ch1_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    late_ok = 1'b1;
    chk("t5_rst_cs", 32'(rom_cs), 0);
    @(negedge clk);
    late_ok = 1'b0;
    chk("t5_idle_cs", 32'(rom_cs), 0);
    ch1_cs = 1'b1;
    ch0_cs = 1'b1;
    #1;
    chk("t5_ch1_ok", 32'(ch1_ok), 0);
    chk("t5_ch0_ok", 32'(ch0_ok), 0);
    ch1_cs = 1'b0;
    ch0_cs = 1'b0;
    @(negedge clk);

    // ch1 walks across the address wrap while ch0 keeps hitting
    exp_q.push_back(17'h00400);
    ch0_addr = 16'h0400;
    ch0_cs   = 1'b1;
    wait_ok(0, "t6_ch0_ok");
    wrap_a[0] = 16'hFFFE; wrap_a[1] = 16'hFFFF; wrap_a[2] = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b1, wrap_a[k]});
      ch1_addr = wrap_a[k];
      ch1_cs   = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        chk("t6_ch0_hold", 32'(ch0_ok), 1);
        if (ch1_ok) begin got = 1'b1; break; end
      end
      chk("t6_ch1_ok", 32'(got), 1);
      chk("t6_ch1_data", 32'(ch1_data), 32'(mem({1'b1, wrap_a[k]})));
    end
    ch0_cs = 1'b0;
    ch1_cs = 1'b0;

    repeat (6) @(negedge clk);
    chk("q_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
